// File: rtl/twi_pkg.sv
// twi_pkg: shared state encoding and bus constants for the direction-aware TWI controller.
package twi_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, WR_DATA, RD_DATA, WAIT_STOP} state_t;
  localparam logic DIR_HOST   = 1'b0;
  localparam logic DIR_MIRROR = 1'b1;
  localparam logic ACK        = 1'b0;
  localparam logic NACK       = 1'b1;
endpackage

// File: rtl/twi_sync_edge.sv
// twi_sync_edge: multi-flop synchronizer with rise/fall detect on the synced value.
module twi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sr;
  logic last;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '1;
      last <= 1'b1;
    end else begin
      sr   <= {sr[STAGES-2:0], d};
      last <= sr[STAGES-1];
    end
  end
  assign q    = sr[STAGES-1];
  assign rise = q & ~last;
  assign fall = ~q & last;
endmodule

// File: rtl/twi_dir_ctrl.sv
// twi_dir_ctrl: tracks host TWI framing and drives only the non-owning side's SDA low enable,
// so the two open-drain buses never hold each other low.
module twi_dir_ctrl
  import twi_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_W      = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       hostScl,
  input  logic       hostSdaIn,
  output logic       hostSdaLow,
  output logic       mirrorScl,
  input  logic       mirrorSdaIn,
  output logic       mirrorSdaLow,
  output logic       busy,
  output logic [6:0] lastAddr,
  output logic       lastRw,
  output logic       nackPulse,
  output logic       timeoutPulse
);
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  logic scl_s, scl_rise, scl_fall;
  logic hsda_s, hsda_rise, hsda_fall;
  logic msda_s, msda_rise_unused, msda_fall_unused;
  twi_sync_edge #(.STAGES(SYNC_STAGES)) u_scl (
    .clk(clk), .rst_n(rstN), .d(hostScl), .q(scl_s), .rise(scl_rise), .fall(scl_fall)
  );
  twi_sync_edge #(.STAGES(SYNC_STAGES)) u_hsda (
    .clk(clk), .rst_n(rstN), .d(hostSdaIn), .q(hsda_s), .rise(hsda_rise), .fall(hsda_fall)
  );
  twi_sync_edge #(.STAGES(SYNC_STAGES)) u_msda (
    .clk(clk), .rst_n(rstN), .d(mirrorSdaIn), .q(msda_s), .rise(msda_rise_unused),
    .fall(msda_fall_unused)
  );
  state_t state, state_n;
  logic dir, dir_n;
  logic [3:0] bit_cnt, cnt_n;
  logic [7:0] sh, sh_n;
  logic bit_hi, hi_n;
  logic [6:0] addr_n;
  logic rw_n, nack_p, to_p;
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic start, stop, scl_edge, timeout;
  assign start    = hsda_fall & scl_s & ~scl_fall;
  assign stop     = hsda_rise & scl_s & ~scl_fall;
  assign scl_edge = scl_rise | scl_fall;
  assign busy     = (state != IDLE);
  assign timeout  = WD_EN && busy && !scl_edge && (wd_cnt == WD_LAST);
  // bit_hi gates the falling edge so the SCL fall right after START does not count as a bit
  always_comb begin
    state_n = state;
    dir_n   = dir;
    cnt_n   = bit_cnt;
    sh_n    = sh;
    hi_n    = bit_hi;
    addr_n  = lastAddr;
    rw_n    = lastRw;
    nack_p  = 1'b0;
    to_p    = 1'b0;
    if (start) begin
      state_n = ADDR;
      dir_n   = DIR_HOST;
      cnt_n   = 4'd0;
      hi_n    = 1'b0;
    end else if (stop || timeout) begin
      state_n = IDLE;
      dir_n   = DIR_HOST;
      cnt_n   = 4'd0;
      hi_n    = 1'b0;
      to_p    = ~stop;
    end else if (state inside {ADDR, WR_DATA, RD_DATA}) begin
      if (scl_rise) begin
        hi_n = 1'b1;
        if (bit_cnt != 4'd8) sh_n = {sh[6:0], (state == RD_DATA) ? msda_s : hsda_s};
        else if (((dir == DIR_MIRROR) ? msda_s : hsda_s) == NACK) begin
          nack_p  = 1'b1;
          state_n = WAIT_STOP;
          dir_n   = DIR_HOST;
          cnt_n   = 4'd0;
          hi_n    = 1'b0;
        end
      end else if (scl_fall && bit_hi) begin
        hi_n = 1'b0;
        if (bit_cnt == 4'd7) begin
          cnt_n = 4'd8;
          dir_n = (state == RD_DATA) ? DIR_HOST : DIR_MIRROR;
        end else if (bit_cnt == 4'd8) begin
          cnt_n = 4'd0;
          if (state == ADDR) begin
            addr_n  = sh[7:1];
            rw_n    = sh[0];
            state_n = sh[0] ? RD_DATA : WR_DATA;
          end
          dir_n = (state_n == RD_DATA) ? DIR_MIRROR : DIR_HOST;
        end else cnt_n = bit_cnt + 4'd1;
      end
    end
  end
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state        <= IDLE;
      dir          <= DIR_HOST;
      bit_cnt      <= 4'd0;
      sh           <= 8'd0;
      bit_hi       <= 1'b0;
      lastAddr     <= 7'd0;
      lastRw       <= 1'b0;
      nackPulse    <= 1'b0;
      timeoutPulse <= 1'b0;
      wd_cnt       <= '0;
      hostSdaLow   <= 1'b0;
      mirrorSdaLow <= 1'b0;
      mirrorScl    <= 1'b1;
    end else begin
      state        <= state_n;
      dir          <= dir_n;
      bit_cnt      <= cnt_n;
      sh           <= sh_n;
      bit_hi       <= hi_n;
      lastAddr     <= addr_n;
      lastRw       <= rw_n;
      nackPulse    <= nack_p;
      timeoutPulse <= to_p;
      wd_cnt       <= (!busy || scl_edge) ? '0 : (&wd_cnt ? wd_cnt : wd_cnt + 1'b1);
      hostSdaLow   <= !to_p && (dir_n == DIR_MIRROR) && !msda_s;
      mirrorSdaLow <= !to_p && (dir_n == DIR_HOST) && !hsda_s;
      mirrorScl    <= scl_s;
    end
  end
endmodule
